// File: rtl/cpu_io_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_io_pkg
// Description : Shared definitions for the memory-mapped UART transmitter:
//               FSM state encoding, register offsets, status bit positions.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_io_pkg;

    // Transmitter FSM states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_t;

    // Register offsets relative to the block base address
    localparam logic [7:0] DATA_OFS = 8'd0;
    localparam logic [7:0] STAT_OFS = 8'd1;

    // Status byte bit positions
    localparam int ST_FULL    = 0;
    localparam int ST_EMPTY   = 1;
    localparam int ST_BUSY    = 2;
    localparam int ST_OVR     = 3;
    localparam int ST_CNT_LSB = 4;

    // The status count field is only 4 bits wide; a 16-deep FIFO reports 15
    function automatic logic [3:0] sat_count(input logic [4:0] cnt);
        return (cnt > 5'd15) ? 4'hF : cnt[3:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo_8.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo_8
// Description : 8-bit synchronous FIFO, power-of-two depth, combinational
//               head read, simultaneous push/pop allowed even when full.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo_8 #(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_push,
    input  logic          i_pop,
    input  logic [7:0]    i_wdata,
    output logic [7:0]    o_rdata,
    output logic          o_full,
    output logic          o_empty,
    output logic [CW-1:0] o_count
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    logic w_do_push;
    logic w_do_pop;

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_rdata   = r_mem[r_rd_ptr];
    // A pop at the same edge frees the slot being written when full
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    // Storage array, written at the tail; needs no reset
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // Pointers wrap naturally at the power-of-two depth; count tracks occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx_port.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_port
// Description : Memory-mapped 8N1 UART transmitter on the CPU data/IO bus.
//               Data register queues bytes; status register reports state.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_port
    import cpu_io_pkg::*;
#(
    parameter logic [7:0] BASE_ADDR    = 8'hF8,
    parameter int         CLKS_PER_BIT = 16,
    parameter int         FIFO_DEPTH   = 4
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic [7:0] addr,
    input  logic       RE,
    input  logic       WE,
    input  logic [7:0] Din,
    output logic [7:0] Dout,
    output logic       hit,
    output logic       txd
);

    localparam int         CW          = $clog2(FIFO_DEPTH) + 1;
    localparam logic [7:0] c_BAUD_MAX  = 8'(CLKS_PER_BIT - 1);
    localparam logic [7:0] c_DATA_ADDR = BASE_ADDR + DATA_OFS;
    localparam logic [7:0] c_STAT_ADDR = BASE_ADDR + STAT_OFS;

    tx_state_t     r_state, w_state_nxt;
    logic [7:0]    r_baud,  w_baud_nxt;
    logic [2:0]    r_bit,   w_bit_nxt;
    logic [7:0]    r_shift, w_shift_nxt;
    logic          r_txd,   w_txd_nxt;
    logic          r_ovr;

    logic          w_sel_data, w_sel_stat;
    logic          w_wr_data, w_rd_stat;
    logic          w_push, w_pop, w_drop;
    logic          w_full, w_empty;
    logic [CW-1:0] w_count;
    logic [7:0]    w_head;
    logic [7:0]    w_status;

    // Bus decode
    assign w_sel_data = (addr == c_DATA_ADDR);
    assign w_sel_stat = (addr == c_STAT_ADDR);
    assign hit        = (w_sel_data || w_sel_stat) && (RE || WE);
    assign w_wr_data  = WE && w_sel_data;
    assign w_rd_stat  = RE && w_sel_stat;
    assign w_push     = w_wr_data && (!w_full || w_pop);
    assign w_drop     = w_wr_data && !w_push;
    assign txd        = r_txd;

    sync_fifo_8 #(
        .DEPTH (FIFO_DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk     (Clock),
        .rst_n   (Reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_wdata (Din),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // Status byte assembly and load-data mux; data register reads as zero
    always_comb begin
        w_status                    = 8'h00;
        w_status[ST_FULL]           = w_full;
        w_status[ST_EMPTY]          = w_empty;
        w_status[ST_BUSY]           = (r_state != ST_IDLE);
        w_status[ST_OVR]            = r_ovr;
        w_status[ST_CNT_LSB +: 4]   = sat_count(5'(w_count));
        Dout                        = w_rd_stat ? w_status : 8'h00;
    end

    // Sticky overrun: a dropped write wins over a clearing status read
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_ovr <= 1'b0;
        end else if (w_drop) begin
            r_ovr <= 1'b1;
        end else if (w_rd_stat) begin
            r_ovr <= 1'b0;
        end
    end

    // Transmitter state register
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_state <= ST_IDLE;
            r_baud  <= 8'd0;
            r_bit   <= 3'd0;
            r_shift <= 8'd0;
            r_txd   <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_baud  <= w_baud_nxt;
            r_bit   <= w_bit_nxt;
            r_shift <= w_shift_nxt;
            r_txd   <= w_txd_nxt;
        end
    end

    // Transmitter next-state: start/data/stop bit timing and FIFO pops
    always_comb begin
        w_state_nxt = r_state;
        w_baud_nxt  = r_baud + 8'd1;
        w_bit_nxt   = r_bit;
        w_shift_nxt = r_shift;
        w_txd_nxt   = r_txd;
        w_pop       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_baud_nxt = 8'd0;
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_shift_nxt = w_head;
                    w_state_nxt = ST_START;
                    w_txd_nxt   = 1'b0;
                end
            end
            ST_START: begin
                if (r_baud == c_BAUD_MAX) begin
                    w_baud_nxt  = 8'd0;
                    w_bit_nxt   = 3'd0;
                    w_txd_nxt   = r_shift[0];
                    w_state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                if (r_baud == c_BAUD_MAX) begin
                    w_baud_nxt = 8'd0;
                    if (r_bit == 3'd7) begin
                        w_txd_nxt   = 1'b1;
                        w_state_nxt = ST_STOP;
                    end else begin
                        w_shift_nxt = {1'b0, r_shift[7:1]};
                        w_txd_nxt   = r_shift[1];
                        w_bit_nxt   = r_bit + 3'd1;
                    end
                end
            end
            ST_STOP: begin
                if (r_baud == c_BAUD_MAX) begin
                    w_baud_nxt = 8'd0;
                    if (!w_empty) begin
                        // Back-to-back: next start bit follows with no idle gap
                        w_pop       = 1'b1;
                        w_shift_nxt = w_head;
                        w_state_nxt = ST_START;
                        w_txd_nxt   = 1'b0;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_baud_nxt  = 8'd0;
                w_txd_nxt   = 1'b1;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: doc/uart_tx_port.md
# uart_tx_port

Memory-mapped UART transmitter that answers the CPU's data-memory/IO bus as a responder. It sits beside the IO port block on the same address/RE/WE/Din/Dout bus. CPU store instructions to its data address queue bytes into a small FIFO, and the block serialises them 8N1, LSB first, on `txd`. CPU load instructions from its status address return FIFO and transmitter state in the same cycle, as the single-cycle datapath requires.

## Interface
- `BASE_ADDR`, 8'hF8: data register at BASE_ADDR, status register at BASE_ADDR+1.
- `CLKS_PER_BIT`, 16: clock cycles per serial bit. Range 2..255.
- `FIFO_DEPTH`, 4: number of queued bytes. Power of two, 2..16.

Ports:
- `Clock` in 1: the single clock. All state changes on the rising edge.
- `Reset` in 1: asynchronous, active-low reset.
- `addr` in 8: bus address (ALU result).
- `RE` in 1: bus read enable (load instruction).
- `WE` in 1: bus write enable (store instruction).
- `Din` in 8: store data.
- `Dout` out 8: load data. Combinational.
- `hit` out 1: combinational; high when `addr` is BASE_ADDR or BASE_ADDR+1 and (RE|WE). Used by the CPU to mux `Dout` and to suppress the RAM write.
- `txd` out 1: serial output. Registered. Idles high.

## Operation
- Status byte: bit0 full, bit1 empty, bit2 busy (FSM not IDLE), bit3 overrun (sticky), bits[7:4] FIFO count (saturates at 15 for reporting).
- Reads:
  - Read of BASE_ADDR+1 returns the status byte.
  - Read of BASE_ADDR returns 8'h00.
  - `Dout` = 0 whenever `hit` is low.
- Write to BASE_ADDR: enqueues `Din` at the edge.
  - The write is accepted if count < FIFO_DEPTH, or if a pop happens at the same edge.
  - Otherwise the byte is dropped and overrun is set.
- Write to BASE_ADDR+1: ignored. `hit` is still high, so the RAM is not written.
- Overrun clears at the edge of a cycle with RE=1 and addr=BASE_ADDR+1. The read in that cycle still returns overrun=1. If a dropped write coincides with the clearing read, set wins.
- FSM states are IDLE, START, DATA, STOP. A baud counter and a 3-bit bit index go with it.
  - IDLE, count>0: pop the head into the shift register, go to START, txd<=0, clear the baud counter.
  - START: after CLKS_PER_BIT cycles go to DATA, bit index 0, txd<=shift[0].
  - DATA: every CLKS_PER_BIT cycles shift right and increment the index. After bit 7 completes, go to STOP with txd<=1.
  - STOP: after CLKS_PER_BIT cycles:
    - if count>0, pop and go directly to START (back-to-back frames);
    - otherwise go to IDLE.
- Reset (asserted, any state, including mid-frame):
  - FIFO emptied, overrun=0, FSM in IDLE, counters 0, txd=1, all immediately.
  - Status reads 8'h02 during and after reset.
  - No partial frame resumes after release.

## Timing
- Reset values: txd=1, `Dout`=0, `hit`=0 (bus idle).
- Enqueue latency:
  - Write at edge k with FSM in IDLE: pop at edge k+1; txd low from edge k+1.
  - Status read in the cycle after edge k shows count=1, empty=0.
- Frame length: exactly 10*CLKS_PER_BIT cycles, measured from the txd falling edge to the end of the stop bit. Each bit lasts exactly CLKS_PER_BIT cycles.
- Back-to-back frames: the next start bit begins on the cycle right after the last stop-bit cycle. There are no idle cycles between frames.
- Simultaneous push and pop at an edge: count unchanged; data ordering preserved.
- Simultaneous RE and WE: not produced by the control unit. If it happens, the write is performed and `Dout` still reflects the read.
- Pointers wrap modulo FIFO_DEPTH. Count is log2(FIFO_DEPTH)+1 bits wide.

## Structure
- Shared package `cpu_io_pkg`:
  - FSM state encoding (2 bits: IDLE=0, START=1, DATA=2, STOP=3);
  - register offsets (DATA_OFS=0, STAT_OFS=1);
  - status bit positions (ST_FULL, ST_EMPTY, ST_BUSY, ST_OVR, ST_CNT_LSB).
- One sub-module, `sync_fifo_8`: an 8-bit-wide synchronous FIFO parameterised by depth, with push, pop, full, empty and count.
  - Same clock and asynchronous active-low reset.
  - Read data is combinational from the head entry.
- The FSM, baud counter, overrun flag and bus decode live in `uart_tx_port`.

## Test plan
- Reset then idle. Expected: txd=1; status read at BASE_ADDR+1 returns 8'h02; `hit`=0 when addr=8'h00.
- CLKS_PER_BIT=4, write 8'hA5. Expected:
  - txd sequence, one symbol per 4 cycles: 0,1,0,1,0,0,1,0,1,1;
  - busy=1 through the frame and 0 after 40 cycles.
- Write 5 bytes in 5 consecutive cycles with FIFO_DEPTH=4. Expected:
  - the first pop frees a slot, so all 5 are accepted and overrun=0;
  - a sixth write issued immediately after is dropped and overrun=1;
  - the 5 frames go out back-to-back in order.
- Overrun clear. Status read returns overrun=1; the following status read returns overrun=0.
- Assert Reset mid-DATA after 3 bits. Expected:
  - txd=1 asynchronously and status=8'h02;
  - after release, nothing is transmitted until a new write.
- Write to BASE_ADDR+1 and read BASE_ADDR. Expected: `hit`=1 and FIFO count unchanged for the write; `Dout`=8'h00 for the read.
